riscv_mem: RTL and testbench

- Memory-access stage of the pipelined core. It sits directly downstream of the execute stage.
- It consumes the EX/MEM-registered ALU result (used as the address), the forwarded store data, the load/store control bits and funct3.
- It runs a request/grant/response transaction on the data-memory bus. It stalls the pipeline until the transaction completes.
- It produces the byte-lane-aligned, sign- or zero-extended load result for write-back.

---
 rtl/riscv_mem_pkg.sv | 63 ++++++
 rtl/riscv_load_align.sv | 28 ++
 rtl/riscv_mem.sv | 125 ++++++++++++
 tb/tb_riscv_mem.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared constants, FSM encoding and access-geometry helpers for the memory stage.
package riscv_mem_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] FUNCT3_LOAD_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LOAD_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LOAD_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LOAD_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LOAD_LHU = 3'b101;

    localparam logic [2:0] FUNCT3_STORE_SB = 3'b000;
    localparam logic [2:0] FUNCT3_STORE_SH = 3'b001;
    localparam logic [2:0] FUNCT3_STORE_SW = 3'b010;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_REQ  = 2'd1,
        MEM_WAIT = 2'd2,
        MEM_DONE = 2'd3
    } mem_state_e;

    typedef enum logic [1:0] {
        SIZE_B = 2'd0,
        SIZE_H = 2'd1,
        SIZE_W = 2'd2
    } mem_size_e;

    // Size comes from funct3[1:0]; the unused encodings fall back to a word.
    function automatic mem_size_e access_size(input logic [2:0] funct3);
        case (funct3[1:0])
            FUNCT3_STORE_SB[1:0]: return SIZE_B;
            FUNCT3_STORE_SH[1:0]: return SIZE_H;
            default:              return SIZE_W;
        endcase
    endfunction

    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] offset);
        case (size)
            SIZE_B:  return 1'b0;
            SIZE_H:  return offset[0];
            default: return |offset;
        endcase
    endfunction

    function automatic logic [3:0] byte_enables(input mem_size_e size, input logic [1:0] offset);
        case (size)
            SIZE_B:  return 4'b0001 << offset;
            SIZE_H:  return 4'b0011 << offset;
            default: return 4'b1111;
        endcase
    endfunction

    // Replicate the store data across every lane so the byte enables pick the right one.
    function automatic logic [XLEN-1:0] store_lanes(input mem_size_e size, input logic [XLEN-1:0] data);
        case (size)
            SIZE_B:  return {4{data[7:0]}};
            SIZE_H:  return {2{data[15:0]}};
            default: return data;
        endcase
    endfunction

endpackage

// File: rtl/riscv_load_align.sv
// Combinational load extractor: selects the addressed byte/half of a bus word
// and sign- or zero-extends it according to funct3.
module riscv_load_align
    import riscv_mem_pkg::*;
(
    input  logic [XLEN-1:0] rdata,
    input  logic [1:0]      offset,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    // Lane select followed by extension; unknown funct3 returns the whole word.
    always_comb begin
        sel_byte = rdata[{offset, 3'b000} +: 8];
        sel_half = offset[1] ? rdata[31:16] : rdata[15:0];
        case (funct3)
            FUNCT3_LOAD_LB:  data = {{24{sel_byte[7]}}, sel_byte};
            FUNCT3_LOAD_LBU: data = {24'b0, sel_byte};
            FUNCT3_LOAD_LH:  data = {{16{sel_half[15]}}, sel_half};
            FUNCT3_LOAD_LHU: data = {16'b0, sel_half};
            default:         data = rdata;
        endcase
    end

endmodule

// File: rtl/riscv_mem.sv
// Memory-access stage: runs one request/grant/response bus transaction per
// aligned load/store, stalls the pipeline meanwhile and formats load data.
//
// Bus handshake: o_dmem_req is held high with addr/we/be/wdata stable until a
// cycle where i_dmem_gnt is high; that cycle completes the request. For loads,
// i_dmem_rvalid is a single-cycle strobe, only looked at after the grant, and
// it carries i_dmem_rdata in that same cycle.
module riscv_mem
    import riscv_mem_pkg::*;
#(
    parameter int BUS_TIMEOUT = 255
) (
    input  logic            i_clk,
    input  logic            i_rstn,
    input  logic            i_mem_ctrl_mem_read,
    input  logic            i_mem_ctrl_mem_write,
    input  logic [2:0]      i_mem_funct3,
    input  logic [XLEN-1:0] i_mem_alu_result,
    input  logic [XLEN-1:0] i_mem_write_data,
    output logic            o_dmem_req,
    output logic            o_dmem_we,
    output logic [XLEN-1:0] o_dmem_addr,
    output logic [XLEN-1:0] o_dmem_wdata,
    output logic [3:0]      o_dmem_be,
    input  logic            i_dmem_gnt,
    input  logic            i_dmem_rvalid,
    input  logic [XLEN-1:0] i_dmem_rdata,
    output logic [XLEN-1:0] o_mem_rd_data,
    output logic            o_mem_stall,
    output logic            o_mem_misaligned,
    output logic            o_mem_bus_err,
    output logic [1:0]      o_dbg_state
);

    localparam int CNT_W = (BUS_TIMEOUT < 1) ? 1 : $clog2(BUS_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(BUS_TIMEOUT);

    mem_state_e      state;
    logic [CNT_W-1:0] tmo_cnt;
    logic [1:0]      offset_q;
    logic [2:0]      funct3_q;
    logic            access;
    mem_size_e       cur_size;
    logic [XLEN-1:0] load_data;

    assign access           = i_mem_ctrl_mem_read | i_mem_ctrl_mem_write;
    assign cur_size         = access_size(i_mem_funct3);
    assign o_mem_misaligned = access & is_misaligned(cur_size, i_mem_alu_result[1:0]);
    assign o_dbg_state      = state;

    riscv_load_align u_load_align (
        .rdata  (i_dmem_rdata),
        .offset (offset_q),
        .funct3 (funct3_q),
        .data   (load_data)
    );

    // Stall while an aligned access waits to start or is on the bus; DONE releases it.
    always_comb begin
        case (state)
            MEM_IDLE: o_mem_stall = access & ~o_mem_misaligned;
            MEM_REQ:  o_mem_stall = 1'b1;
            MEM_WAIT: o_mem_stall = 1'b1;
            default:  o_mem_stall = 1'b0;
        endcase
    end

    // Transaction FSM with registered bus outputs, load result and timeout.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state         <= MEM_IDLE;
            tmo_cnt       <= '0;
            o_dmem_req    <= 1'b0;
            o_dmem_we     <= 1'b0;
            o_dmem_addr   <= '0;
            o_dmem_wdata  <= '0;
            o_dmem_be     <= 4'b0000;
            offset_q      <= 2'b00;
            funct3_q      <= 3'b000;
            o_mem_rd_data <= '0;
            o_mem_bus_err <= 1'b0;
        end else begin
            o_mem_bus_err <= 1'b0;
            case (state)
                MEM_IDLE: begin
                    if (access && !o_mem_misaligned) begin
                        o_dmem_req   <= 1'b1;
                        o_dmem_we    <= i_mem_ctrl_mem_write;
                        o_dmem_addr  <= {i_mem_alu_result[XLEN-1:2], 2'b00};
                        o_dmem_be    <= byte_enables(cur_size, i_mem_alu_result[1:0]);
                        o_dmem_wdata <= store_lanes(cur_size, i_mem_write_data);
                        offset_q     <= i_mem_alu_result[1:0];
                        funct3_q     <= i_mem_funct3;
                        tmo_cnt      <= '0;
                        state        <= MEM_REQ;
                    end
                end
                MEM_REQ, MEM_WAIT: begin
                    // The timeout wins over any grant or response arriving in the same cycle.
                    if (tmo_cnt == TMO_LAST) begin
                        o_dmem_req    <= 1'b0;
                        o_mem_bus_err <= 1'b1;
                        o_mem_rd_data <= '0;
                        state         <= MEM_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                        if (state == MEM_REQ) begin
                            if (i_dmem_gnt) begin
                                o_dmem_req <= 1'b0;
                                state      <= o_dmem_we ? MEM_DONE : MEM_WAIT;
                            end
                        end else if (i_dmem_rvalid) begin
                            o_mem_rd_data <= load_data;
                            state         <= MEM_DONE;
                        end
                    end
                end
                default: begin
                    state <= MEM_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_mem.sv
// Self-checking bench for riscv_mem: directed scenarios plus randomized
// loads/stores against a behavioural model of the memory stage.
module tb_riscv_mem;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] alu_result = '0;
    logic [31:0] write_data = '0;
    logic        dmem_gnt = 1'b0;
    logic        dmem_rvalid = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic [31:0] mem_rd_data;
    logic        mem_stall;
    logic        mem_misaligned;
    logic        mem_bus_err;
    logic [1:0]  dbg_state;

    riscv_mem #(.BUS_TIMEOUT(TMO)) dut (
        .i_clk                (clk),
        .i_rstn               (rst_n),
        .i_mem_ctrl_mem_read  (mem_read),
        .i_mem_ctrl_mem_write (mem_write),
        .i_mem_funct3         (funct3),
        .i_mem_alu_result     (alu_result),
        .i_mem_write_data     (write_data),
        .o_dmem_req           (dmem_req),
        .o_dmem_we            (dmem_we),
        .o_dmem_addr          (dmem_addr),
        .o_dmem_wdata         (dmem_wdata),
        .o_dmem_be            (dmem_be),
        .i_dmem_gnt           (dmem_gnt),
        .i_dmem_rvalid        (dmem_rvalid),
        .i_dmem_rdata         (dmem_rdata),
        .o_mem_rd_data        (mem_rd_data),
        .o_mem_stall          (mem_stall),
        .o_mem_misaligned     (mem_misaligned),
        .o_mem_bus_err        (mem_bus_err),
        .o_dbg_state          (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    logic [31:0] rd_model = '0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Reference model: access width in bytes from funct3.
    function automatic int size_of(input logic [2:0] f3);
        if (f3 == 3'b000 || f3 == 3'b100) return 1;
        if (f3 == 3'b001 || f3 == 3'b101) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] word, input logic [31:0] addr,
                                             input logic [2:0] f3);
        int     n;
        int     lane;
        longint v;
        n    = size_of(f3);
        lane = (n == 4) ? 0 : int'(addr % 4);
        v    = longint'((word >> (8 * lane))) & ((64'd1 << (8 * n)) - 1);
        if (n < 4 && f3[2] == 1'b0 && v >= longint'(64'd1 << (8 * n - 1)))
            v = v - longint'(64'd1 << (8 * n));
        return v[31:0];
    endfunction

    function automatic logic [31:0] ref_be(input logic [31:0] addr, input logic [2:0] f3);
        int n;
        int be;
        n  = size_of(f3);
        be = ((1 << n) - 1) << ((n == 4) ? 0 : int'(addr % 4));
        return 32'(be);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [31:0] data, input logic [2:0] f3);
        int n;
        n = size_of(f3);
        if (n == 1) return (data & 32'hFF) * 32'h0101_0101;
        if (n == 2) return (data & 32'hFFFF) * 32'h0001_0001;
        return data;
    endfunction

    // Driver + bus responder: gnt on the k-th request cycle, rvalid on the
    // m-th cycle after the grant; checks bus fields, stall length, result.
    task automatic do_access(input bit is_load, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] wd, input int k, input int m,
                             input logic [31:0] word, input string tag);
        int          n;
        bit          mis;
        bit          tmo;
        int          exp_stall;
        int          exp_req;
        logic [31:0] rd_next;
        int          stall_cnt = 0;
        int          req_cnt = 0;
        int          wait_cnt = 0;
        int          err_cnt = 0;
        int          cyc = 0;
        bit          gnt_given = 1'b0;
        bit          done = 1'b0;

        n   = size_of(f3);
        mis = (addr % n) != 0;
        tmo = !mis && (is_load ? (k + m > TMO) : (k > TMO));
        if (mis)      exp_stall = 0;
        else if (tmo) exp_stall = TMO + 2;
        else          exp_stall = is_load ? 1 + k + m : 1 + k;
        if (mis)      exp_req = 0;
        else if (tmo) exp_req = (k > TMO + 1) ? TMO + 1 : ((is_load && k <= TMO) ? k : TMO + 1);
        else          exp_req = k;
        if (!mis) begin
            if (tmo)          rd_next = '0;
            else if (is_load) rd_next = ref_load(word, addr, f3);
            else              rd_next = rd_model;
            exp_q.push_back(rd_next);
        end

        @(negedge clk);
        mem_read   = is_load;
        mem_write  = !is_load;
        funct3     = f3;
        alu_result = addr;
        write_data = wd;
        #1;
        check({tag, " misaligned"}, 32'(mem_misaligned), 32'(mis));
        while (!done && cyc < 40) begin
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b0;
            dmem_rdata  = $urandom;
            if (mem_bus_err) err_cnt++;
            if (!mem_stall) begin
                done = 1'b1;
            end else begin
                stall_cnt++;
                if (dmem_req) begin
                    req_cnt++;
                    if (req_cnt == 1) begin
                        check({tag, " addr"}, dmem_addr, addr & 32'hFFFF_FFFC);
                        check({tag, " be"}, 32'(dmem_be), ref_be(addr, f3));
                        check({tag, " we"}, 32'(dmem_we), 32'(!is_load));
                        if (!is_load) check({tag, " wdata"}, dmem_wdata, ref_wdata(wd, f3));
                    end
                    if (req_cnt == k) begin
                        dmem_gnt  = 1'b1;
                        gnt_given = 1'b1;
                    end
                end else if (gnt_given && is_load) begin
                    wait_cnt++;
                    if (wait_cnt == m) begin
                        dmem_rvalid = 1'b1;
                        dmem_rdata  = word;
                    end
                end
                @(negedge clk);
                #1;
            end
            cyc++;
        end
        check({tag, " completed"}, 32'(done), 32'd1);
        check({tag, " stall cycles"}, 32'(stall_cnt), 32'(exp_stall));
        check({tag, " req cycles"}, 32'(req_cnt), 32'(exp_req));
        check({tag, " bus_err in done"}, 32'(mem_bus_err), 32'(tmo));
        if (!mis) rd_model = exp_q.pop_front();
        check({tag, " rd_data"}, mem_rd_data, rd_model);
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(negedge clk);
        #1;
        if (mem_bus_err) err_cnt++;
        check({tag, " bus_err pulses"}, 32'(err_cnt), 32'(tmo));
        check({tag, " back to idle"}, 32'(dbg_state), 32'd0);
        check({tag, " rd_data held"}, mem_rd_data, rd_model);
    endtask

    initial begin
        // Reset
        repeat (2) @(negedge clk);
        #1;
        check("reset req", 32'(dmem_req), 32'd0);
        check("reset be", 32'(dmem_be), 32'd0);
        check("reset rd_data", mem_rd_data, 32'd0);
        check("reset stall", 32'(mem_stall), 32'd0);
        check("reset state", 32'(dbg_state), 32'd0);
        rst_n = 1'b1;

        // Directed scenarios
        do_access(1'b0, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 1, 0, '0, "sw_0x100");
        do_access(1'b0, 3'b000, 32'h0000_0103, 32'h0000_00A5, 1, 0, '0, "sb_0x103");
        do_access(1'b1, 3'b000, 32'h0000_0102, '0, 3, 1, 32'h12F4_5678, "lb_0x102");
        do_access(1'b1, 3'b100, 32'h0000_0102, '0, 3, 1, 32'h12F4_5678, "lbu_0x102");
        do_access(1'b1, 3'b101, 32'h0000_0102, '0, 3, 1, 32'h12F4_5678, "lhu_0x102");
        do_access(1'b1, 3'b001, 32'h0000_0202, '0, 1, 1, 32'h8001_7FFF, "lh_upper");
        do_access(1'b0, 3'b001, 32'h0000_0302, 32'h1234_BEEF, 2, 0, '0, "sh_upper");
        do_access(1'b1, 3'b010, 32'h0000_0101, '0, 1, 1, 32'h5555_5555, "lw_misaligned");
        do_access(1'b1, 3'b001, 32'h0000_0103, '0, 1, 1, 32'h5555_5555, "lh_misaligned");
        do_access(1'b1, 3'b010, 32'h0000_0300, '0, 1, 99, 32'h7777_7777, "lw_timeout");
        do_access(1'b0, 3'b010, 32'h0000_0400, 32'h0BAD_F00D, 99, 0, '0, "sw_no_gnt");
        do_access(1'b1, 3'b111, 32'h0000_0504, '0, 1, 1, 32'h89AB_CDEF, "illegal_f3");

        // Randomized loads and stores
        for (int t = 0; t < 60; t++) begin
            bit          ld;
            logic [2:0]  f3;
            logic [31:0] a;
            int          sel;
            ld  = ($urandom_range(0, 1) == 1);
            sel = $urandom_range(0, 9);
            if (ld) begin
                case (sel % 6)
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    3: f3 = 3'b100;
                    4: f3 = 3'b101;
                    default: f3 = (sel > 7) ? 3'b110 : 3'b010;
                endcase
            end else begin
                case (sel % 4)
                    0: f3 = 3'b000;
                    1: f3 = 3'b001;
                    2: f3 = 3'b010;
                    default: f3 = (sel > 7) ? 3'b011 : 3'b000;
                endcase
            end
            a = $urandom;
            if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) a = a & 32'hFFFF_FFFC;
            do_access(ld, f3, a, $urandom, $urandom_range(1, 5), $urandom_range(1, 3), $urandom,
                      $sformatf("rand%0d", t));
        end

        // Load a known value, then reset asynchronously while waiting for rvalid
        do_access(1'b1, 3'b010, 32'h0000_0600, '0, 1, 1, 32'hCAFE_F00D, "lw_before_reset");
        @(negedge clk);
        mem_read   = 1'b1;
        funct3     = 3'b010;
        alu_result = 32'h0000_0200;
        @(negedge clk);
        #1;
        check("rst_seq req", 32'(dmem_req), 32'd1);
        dmem_gnt = 1'b1;
        @(negedge clk);
        #1;
        dmem_gnt = 1'b0;
        check("rst_seq in wait", 32'(dbg_state), 32'd2);
        rst_n = 1'b0;
        #1;
        check("async rst req", 32'(dmem_req), 32'd0);
        check("async rst addr", dmem_addr, 32'd0);
        check("async rst be", 32'(dmem_be), 32'd0);
        check("async rst rd_data", mem_rd_data, 32'd0);
        check("async rst state", 32'(dbg_state), 32'd0);
        rd_model = '0;
        mem_read = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            dmem_gnt    = 1'b1;
            dmem_rvalid = 1'b1;
            dmem_rdata  = 32'hFFFF_FFFF;
            #1;
            check("late rvalid rd_data", mem_rd_data, rd_model);
            check("late rvalid state", 32'(dbg_state), 32'd0);
        end
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b0;

        // Report
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
